// File: rtl/bn_pkg.sv
// bn_pkg: shared types and helpers for the batch-norm + activation pipeline.
//   bn_mode_e     per-row activation select (BN only, ReLU, ReLU6, passthrough)
//   STAGES        number of register stages between accept and out_row
//   round_half()  rounding offset added before the FRAC_W arithmetic shift
//   relu6_limit() ReLU6 upper clamp: min(6.0 in IO_FRAC format, max positive)
package bn_pkg;

    typedef enum logic [1:0] {
        BN_ONLY  = 2'd0,
        BN_RELU  = 2'd1,
        BN_RELU6 = 2'd2,
        BN_PASS  = 2'd3
    } bn_mode_e;

    localparam int STAGES = 2;

    function automatic int round_half(input int frac_w);
        return (frac_w > 0) ? (1 << (frac_w - 1)) : 0;
    endfunction

    // 6.0 may not be representable for narrow lanes, so clip to the lane max.
    function automatic int relu6_limit(input int data_w, input int io_frac);
        longint six;
        longint maxp;
        six  = longint'(6) << io_frac;
        maxp = (longint'(1) << (data_w - 1)) - 1;
        return int'((six < maxp) ? six : maxp);
    endfunction

endpackage

// File: rtl/bn_lane.sv
// bn_lane: one lane of stage-2 arithmetic, purely combinational.
//   p    in  full-precision product A*x (DATA_W+COEF_W, signed)
//   b    in  B coefficient captured with the product
//   x    in  original lane input, used by passthrough
//   mode in  activation mode for the row
//   y    out activated, saturated result
module bn_lane
    import bn_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int COEF_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int IO_FRAC = 8
) (
    input  logic signed [DATA_W+COEF_W-1:0] p,
    input  logic signed [COEF_W-1:0]        b,
    input  logic signed [DATA_W-1:0]        x,
    input  bn_mode_e                        mode,
    output logic signed [DATA_W-1:0]        y
);

    localparam int P_W = DATA_W + COEF_W;
    // Two guard bits: one for the rounding add, one for adding B.
    localparam int S_W = P_W + 2;

    localparam logic signed [S_W-1:0]    HALF   = S_W'(round_half(FRAC_W));
    localparam logic signed [DATA_W-1:0] R6_LIM = DATA_W'(relu6_limit(DATA_W, IO_FRAC));
    localparam logic signed [DATA_W-1:0] Y_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Y_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [S_W-1:0]    r;
    logic signed [S_W-1:0]    s;
    logic signed [DATA_W-1:0] sat;
    logic                     ovf;

    always_comb begin
        // Round half up: add 0.5 LSB then floor via arithmetic shift.
        r   = (S_W'(p) + HALF) >>> FRAC_W;
        s   = r + S_W'(b);
        // Fits in DATA_W only if all bits above the lane sign match it.
        ovf = (s[S_W-1:DATA_W-1] != {(S_W-DATA_W+1){s[S_W-1]}});
        sat = ovf ? (s[S_W-1] ? Y_MIN : Y_MAX) : s[DATA_W-1:0];

        y = sat;
        case (mode)
            BN_RELU: begin
                if (sat < 0) y = '0;
            end
            BN_RELU6: begin
                if (sat < 0)           y = '0;
                else if (sat > R6_LIM) y = R6_LIM;
            end
            BN_PASS: y = x;
            default: y = sat;
        endcase
    end

endmodule

// File: rtl/bn_act_pipe.sv
// bn_act_pipe: two-stage batch-norm + activation engine,
// y = act(sat(round(A*x) + B)) per lane, with a per-lane coefficient bank.
//   CLK, RST              clock, async active-low reset
//   in_row/in_valid/in_ready/in_mode   input row handshake + activation mode
//   out_row/out_valid/out_ready        output row handshake (full backpressure)
//   coef_we/coef_idx/coef_a/coef_b     coefficient bank write port
// Stage 1 registers A*x together with B, x and mode so rows in flight never
// see later bank writes. Stage 2 is the output register fed by bn_lane.
module bn_act_pipe
    import bn_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int COEF_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int IO_FRAC = 8,
    parameter int N       = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N*DATA_W-1:0]    in_row,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_mode,
    output logic [N*DATA_W-1:0]    out_row,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   coef_we,
    input  logic [$clog2(N)-1:0]   coef_idx,
    input  logic [COEF_W-1:0]      coef_a,
    input  logic [COEF_W-1:0]      coef_b
);

    localparam int IDX_W = $clog2(N);
    localparam int P_W   = DATA_W + COEF_W;
    localparam logic [COEF_W-1:0] A_ONE = COEF_W'(1 << FRAC_W);

    typedef struct packed {
        logic [N-1:0][P_W-1:0]    p;
        logic [N-1:0][COEF_W-1:0] b;
        logic [N-1:0][DATA_W-1:0] x;
        bn_mode_e                 mode;
    } s1_t;

    logic [N-1:0][COEF_W-1:0] a_bank;
    logic [N-1:0][COEF_W-1:0] b_bank;
    logic [N-1:0][DATA_W-1:0] x_in;
    logic [N-1:0][P_W-1:0]    prod;
    logic [N-1:0][DATA_W-1:0] lane_y;
    logic [N-1:0][DATA_W-1:0] out_q;
    s1_t                      s1_q;
    logic [STAGES:1]          vld_pipe;
    logic                     s1_adv;

    assign x_in      = in_row;
    assign out_row   = out_q;
    assign out_valid = vld_pipe[2];
    assign s1_adv    = !vld_pipe[2] || out_ready;
    assign in_ready  = !vld_pipe[1] || s1_adv;

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign prod[i] = P_W'(signed'(a_bank[i])) * P_W'(signed'(x_in[i]));

        bn_lane #(
            .DATA_W (DATA_W),
            .COEF_W (COEF_W),
            .FRAC_W (FRAC_W),
            .IO_FRAC(IO_FRAC)
        ) u_lane (
            .p   (s1_q.p[i]),
            .b   (s1_q.b[i]),
            .x   (s1_q.x[i]),
            .mode(s1_q.mode),
            .y   (lane_y[i])
        );
    end

    // Coefficient bank. Indices >= N never match a lane and are dropped.
    // The bank is read combinationally at accept, so a same-edge write is
    // only seen by later rows.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < N; i++) begin
                a_bank[i] <= A_ONE;
                b_bank[i] <= '0;
            end
        end else if (coef_we) begin
            for (int i = 0; i < N; i++) begin
                if (coef_idx == IDX_W'(i)) begin
                    a_bank[i] <= coef_a;
                    b_bank[i] <= coef_b;
                end
            end
        end
    end

    // Stage 1: product, B, x and mode for the accepted row.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_pipe[1] <= 1'b0;
            s1_q        <= '0;
        end else if (in_ready) begin
            vld_pipe[1] <= in_valid;
            if (in_valid) begin
                s1_q.p    <= prod;
                s1_q.b    <= b_bank;
                s1_q.x    <= x_in;
                s1_q.mode <= bn_mode_e'(in_mode);
            end
        end
    end

    // Stage 2: output register; holds while downstream stalls.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_pipe[2] <= 1'b0;
            out_q       <= '0;
        end else if (s1_adv) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) out_q <= lane_y;
        end
    end

endmodule

// File: tb/tb_bn_act_pipe.sv
// tb_bn_act_pipe: directed self-checking bench for bn_act_pipe.
module tb_bn_act_pipe;

    localparam int N  = 32;
    localparam int DW = 16;
    localparam int CW = 16;

    typedef logic [N-1:0][DW-1:0] row_t;

    logic                 CLK;
    logic                 RST;
    row_t                 in_row_p;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_mode;
    row_t                 out_row_p;
    logic                 out_valid;
    logic                 out_ready;
    logic                 coef_we;
    logic [$clog2(N)-1:0] coef_idx;
    logic [CW-1:0]        coef_a;
    logic [CW-1:0]        coef_b;

    int n_checks = 0;
    int n_fail   = 0;

    bn_act_pipe #(.DATA_W(DW), .COEF_W(CW), .FRAC_W(8), .IO_FRAC(8), .N(N)) dut (
        .CLK(CLK), .RST(RST),
        .in_row(in_row_p), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .out_row(out_row_p), .out_valid(out_valid), .out_ready(out_ready),
        .coef_we(coef_we), .coef_idx(coef_idx), .coef_a(coef_a), .coef_b(coef_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs;
        in_row_p = '0; in_valid = 0; in_mode = 2'd0; out_ready = 1;
        coef_we = 0; coef_idx = '0; coef_a = '0; coef_b = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        RST = 0;
        repeat (2) tick();
        RST = 1;
        tick();
    endtask

    task automatic write_coef(input int idx, input logic [CW-1:0] a, input logic [CW-1:0] b);
        coef_we = 1; coef_idx = idx[$clog2(N)-1:0]; coef_a = a; coef_b = b;
        tick();
        coef_we = 0;
    endtask

    task automatic send_row(input row_t row, input logic [1:0] mode, output row_t res, output logic got);
        got = 0; res = '0;
        in_row_p = row; in_mode = mode; in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        for (int c = 0; c < 8 && !got; c++) begin
            if (out_valid) begin res = out_row_p; got = 1; end
            tick();
        end
    endtask

    function automatic row_t bp_row(input int k);
        row_t r;
        for (int i = 0; i < N; i++) r[i] = DW'((k * 97 + i * 13 - 200) * 8);
        return r;
    endfunction

    // Identity bank: mode 0 returns x, mode 1 zeroes negatives.
    function automatic row_t bp_exp(input int k);
        row_t x = bp_row(k);
        row_t e;
        for (int i = 0; i < N; i++) e[i] = ((k % 2 == 1) && x[i][DW-1]) ? '0 : x[i];
        return e;
    endfunction

    task automatic test_reset;
        idle_inputs();
        RST = 0;
        #3;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (out_row_p !== '0) begin n_fail++; $display("FAIL reset_out_row: got %h want 0", out_row_p); end
        tick();
        RST = 1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_identity;
        row_t r;
        do_reset();
        for (int i = 0; i < N; i++) r[i] = DW'(i << 8);
        in_row_p = r; in_mode = 2'd0; out_ready = 1; in_valid = 1;
        tick();
        in_valid = 0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ident_early_valid: got %b want 0", out_valid); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ident_lat_valid: got %b want 1", out_valid); end
        n_checks++;
        if (out_row_p !== r) begin n_fail++; $display("FAIL ident_row: got %h want %h", out_row_p, r); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ident_pulse: got %b want 0", out_valid); end
    endtask

    task automatic test_coef_lane3;
        row_t r, res;
        logic got;
        do_reset();
        write_coef(3, 16'h0180, 16'h0100);
        r = '0; r[3] = 16'h0200; r[5] = 16'h0123;
        send_row(r, 2'd0, res, got);
        n_checks++;
        if (!got || res[3] !== 16'h0400) begin n_fail++; $display("FAIL coef3_bn: got %h want 0400", res[3]); end
        n_checks++;
        if (!got || res[5] !== 16'h0123) begin n_fail++; $display("FAIL coef3_other_lane: got %h want 0123", res[5]); end
        r[3] = 16'hFC00;
        send_row(r, 2'd1, res, got);
        n_checks++;
        if (!got || res[3] !== 16'h0000) begin n_fail++; $display("FAIL coef3_relu: got %h want 0000", res[3]); end
    endtask

    task automatic test_round_sat;
        row_t r, res;
        logic got;
        do_reset();
        write_coef(0, 16'h0080, 16'h0000);
        write_coef(1, 16'h7FFF, 16'h0000);
        write_coef(2, 16'h7FFF, 16'h0000);
        write_coef(4, 16'h0080, 16'h0000);
        write_coef(5, 16'h0080, 16'h0000);
        write_coef(6, 16'h0100, 16'h7FFF);
        write_coef(7, 16'h0100, 16'h8000);
        r = '0;
        r[0] = 16'h0001; r[1] = 16'h7FFF; r[2] = 16'h8000; r[4] = 16'hFFFF;
        r[5] = 16'hFFFD; r[6] = 16'h0100; r[7] = 16'hFF00;
        send_row(r, 2'd0, res, got);
        n_checks++;
        if (!got || res[0] !== 16'h0001) begin n_fail++; $display("FAIL round_half_up: got %h want 0001", res[0]); end
        n_checks++;
        if (!got || res[1] !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos: got %h want 7fff", res[1]); end
        n_checks++;
        if (!got || res[2] !== 16'h8000) begin n_fail++; $display("FAIL sat_neg: got %h want 8000", res[2]); end
        n_checks++;
        if (!got || res[4] !== 16'h0000) begin n_fail++; $display("FAIL round_neg_half: got %h want 0000", res[4]); end
        n_checks++;
        if (!got || res[5] !== 16'hFFFF) begin n_fail++; $display("FAIL round_neg: got %h want ffff", res[5]); end
        n_checks++;
        if (!got || res[6] !== 16'h7FFF) begin n_fail++; $display("FAIL sat_add_pos: got %h want 7fff", res[6]); end
        n_checks++;
        if (!got || res[7] !== 16'h8000) begin n_fail++; $display("FAIL sat_add_neg: got %h want 8000", res[7]); end
    endtask

    task automatic test_relu6_pass;
        row_t r, res;
        logic got;
        do_reset();
        r = '0; r[0] = 16'h0A00; r[1] = 16'h0300; r[2] = 16'hFF00;
        send_row(r, 2'd2, res, got);
        n_checks++;
        if (!got || res[0] !== 16'h0600) begin n_fail++; $display("FAIL relu6_clamp: got %h want 0600", res[0]); end
        n_checks++;
        if (!got || res[1] !== 16'h0300) begin n_fail++; $display("FAIL relu6_inrange: got %h want 0300", res[1]); end
        n_checks++;
        if (!got || res[2] !== 16'h0000) begin n_fail++; $display("FAIL relu6_neg: got %h want 0000", res[2]); end
        write_coef(0, 16'h0000, 16'h0000);
        r = '0; r[0] = 16'h1234; r[1] = 16'h8000;
        send_row(r, 2'd3, res, got);
        n_checks++;
        if (!got || res[0] !== 16'h1234) begin n_fail++; $display("FAIL pass_a0: got %h want 1234", res[0]); end
        n_checks++;
        if (!got || res[1] !== 16'h8000) begin n_fail++; $display("FAIL pass_min: got %h want 8000", res[1]); end
        send_row(r, 2'd0, res, got);
        n_checks++;
        if (!got || res[0] !== 16'h0000) begin n_fail++; $display("FAIL bn_a0: got %h want 0000", res[0]); end
    endtask

    task automatic test_backpressure;
        row_t exp_q [$];
        row_t hold_row, e;
        logic hold_v;
        int   k, got;
        do_reset();
        k = 0; got = 0; hold_v = 0; hold_row = '0;
        for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
            out_ready = (cyc < 4) ? 1'b0 : (cyc == 4) ? 1'b1 : 1'($urandom_range(0, 1));
            in_valid  = (k < 8);
            in_mode   = (k % 2 == 1) ? 2'd1 : 2'd0;
            in_row_p  = bp_row(k);
            #2;
            if (cyc == 2 || cyc == 3) begin
                n_checks++;
                if (in_ready !== 1'b0 || k != 2) begin
                    n_fail++; $display("FAIL bp_full: in_ready %b rows %0d want 0 and 2", in_ready, k);
                end
            end
            if (cyc == 4) begin
                n_checks++;
                if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_return: got %b want 1", in_ready); end
            end
            if (hold_v) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_row_p !== hold_row) begin
                    n_fail++; $display("FAIL bp_stall_stable: valid %b row %h want 1 %h", out_valid, out_row_p, hold_row);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra_row: got %h want none", out_row_p);
                end else begin
                    e = exp_q.pop_front();
                    if (out_row_p !== e) begin n_fail++; $display("FAIL bp_row_%0d: got %h want %h", got, out_row_p, e); end
                end
                got++;
            end
            hold_v   = out_valid && !out_ready;
            hold_row = out_row_p;
            if (in_valid && in_ready) begin
                exp_q.push_back(bp_exp(k));
                k++;
            end
            @(posedge CLK);
            #1;
        end
        in_valid = 0; out_ready = 1;
        n_checks++;
        if (got != 8 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL bp_count: got %0d rows, %0d pending want 8, 0", got, exp_q.size());
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_dup: got %b want 0", out_valid); end
        end
    endtask

    task automatic test_coef_collision;
        row_t r;
        do_reset();
        r = '0; r[0] = 16'h0100;
        in_row_p = r; in_mode = 2'd0; in_valid = 1; out_ready = 1;
        coef_we = 1; coef_idx = '0; coef_a = 16'h0200; coef_b = 16'h0010;
        tick();
        coef_we = 0;
        tick();
        in_valid = 0;
        n_checks++;
        if (out_valid !== 1'b1 || out_row_p[0] !== 16'h0100) begin
            n_fail++; $display("FAIL collide_old: valid %b y %h want 1 0100", out_valid, out_row_p[0]);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_row_p[0] !== 16'h0210) begin
            n_fail++; $display("FAIL collide_new: valid %b y %h want 1 0210", out_valid, out_row_p[0]);
        end
    endtask

    task automatic test_reset_mid;
        row_t r, res;
        logic got;
        do_reset();
        write_coef(0, 16'h0000, 16'h0050);
        r = '0; r[0] = 16'h0100;
        in_row_p = r; in_mode = 2'd0; in_valid = 1; out_ready = 1;
        repeat (2) tick();
        RST = 0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_row_p !== '0) begin
            n_fail++; $display("FAIL midrst_flush: valid %b row %h want 0 0", out_valid, out_row_p);
        end
        tick();
        in_valid = 0;
        RST = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_partial: got %b want 0", out_valid); end
        end
        send_row(r, 2'd0, res, got);
        n_checks++;
        if (!got || res[0] !== 16'h0100) begin n_fail++; $display("FAIL midrst_bank: got %h want 0100", res[0]); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_coef_lane3();
        test_round_sat();
        test_relu6_pass();
        test_backpressure();
        test_coef_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
